pulse_burst_generator: RTL and testbench
========================================

Name: pulse_burst_generator

Overview:
Multi-channel successor to the single-channel periodic pulse generator. One shared period counter drives N_CHANNELS gate outputs, each with its own programmable delay and width inside the period. It runs either continuously or in triggered bursts of burst_len periods. It sits in the same clock domain as the ADC/DAC datapath and provides gating, start markers and the sample index to downstream acquisition blocks.

Parameters:
N_CHANNELS, 2, number of independent gate outputs
PULSE_WIDTH_WIDTH, 8, bit width of each channel's width field
PULSE_PERIOD_WIDTH, 16, bit width of period, delay and counter
BURST_WIDTH, 16, bit width of burst length and period index

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
mode  in  1  0 = continuous, 1 = triggered burst
trig  in  1  level input; its rising edge is used (continuous: restart; burst: start)
abort  in  1  forces IDLE on the next edge
pulse_period  in  PULSE_PERIOD_WIDTH  period in clk cycles
pulse_delay  in  N_CHANNELS*PULSE_PERIOD_WIDTH  packed per-channel delay; channel i at [i*W +: W]
pulse_width  in  N_CHANNELS*PULSE_WIDTH_WIDTH  packed per-channel width
burst_len  in  BURST_WIDTH  periods per burst
valid  out  N_CHANNELS  per-channel gate
cnt  out  PULSE_PERIOD_WIDTH  counter value, registered
start  out  1  high on the first cycle of each active period
busy  out  1  high in CONT or BURST state
done  out  1  one-cycle pulse at burst completion
pulse_idx  out  BURST_WIDTH  current period index within the burst (0 in CONT)

Behaviour:
- Reset values: state = IDLE; cnt_reg, cnt, pulse_idx = 0; valid, start, busy, done = 0; trig_d = 0.
  - Because trig_d resets to 0, trig held high through reset counts as a rising edge.
- trig_rise = trig & ~trig_d.
- States and transitions:
  - IDLE, mode = 0 -> CONT next cycle, cnt_reg = 0.
  - IDLE, mode = 1, trig_rise, burst_len != 0 -> BURST, cnt_reg = 0, idx = 0.
  - IDLE, trig_rise with burst_len = 0 -> ignored; no done.
  - CONT, trig_rise -> cnt_reg = 0 next cycle (restart).
  - CONT, mode = 1 -> stays CONT until wrap, then IDLE.
  - BURST, wrap with idx == burst_len-1 -> IDLE and done = 1 for one cycle.
  - BURST, wrap otherwise -> idx + 1.
  - BURST ignores trig and mode changes (no retrigger).
  - abort in CONT or BURST -> IDLE next cycle, no done. If mode = 0, CONT is re-entered one cycle later.
  - rst overrides abort; abort overrides trig and wrap.
- Counter, active states only:
  - last = (cnt_reg + 1 >= pulse_period), evaluated in PULSE_PERIOD_WIDTH+1 bits.
  - last -> cnt_reg = 0 (wrap), else cnt_reg + 1.
  - pulse_period of 0 or 1 -> cnt_reg stays 0; every cycle is a wrap.
  - A period reduced below the current cnt_reg wraps on the next edge.
  - In IDLE, cnt_reg = 0.
- Outputs are registered one cycle behind the internal state:
  - cnt <= cnt_reg.
  - busy <= active.
  - start <= active & (cnt_reg == 0).
  - pulse_idx <= idx.
  - valid[i] <= active & (cnt_reg >= delay_i) & (cnt_reg - delay_i < width_i), evaluated in PULSE_PERIOD_WIDTH+1 bits with width zero-extended.
- Channel corner cases:
  - width_i = 0 -> channel never asserts.
  - delay_i >= pulse_period -> channel never asserts.
  - A window running past period end is truncated at wrap; it never spills into the next period or past burst end.
- Inputs pulse_period, pulse_delay, pulse_width and burst_len are sampled every cycle (not latched). Changes take effect on the next counter evaluation.
- done rises in the same cycle that busy falls.

Test Plan:
- Continuous, period = 5, delay0 = 1, width0 = 2, delay1 = 0, width1 = 5 -> after rst release: busy = 1; cnt 0,1,2,3,4,0…; valid[0] high for cnt 1-2; valid[1] always high; start each time cnt = 0.
- Burst, burst_len = 3, period = 4, single trig pulse -> exactly 12 busy cycles; pulse_idx 0,1,2; three start pulses; done high one cycle as busy falls; second trig during burst has no effect.
- Burst active, abort at cnt = 2 of idx = 1 -> busy = 0 and valid = 0 two edges later; done never asserts.
- Edge cases: period = 0 and 1 -> cnt stuck at 0 and start every cycle; width0 = 0 -> valid[0] stays 0; delay0 = 7 with period = 6 -> valid[0] stays 0; burst_len = 0 with trig -> stays IDLE.
- Continuous, trig rise at cnt = 3, period = 10 -> cnt reads 0 within two cycles; switching mode to 1 mid-period -> IDLE only after cnt = 9.
- rst asserted mid-burst -> all outputs 0 next cycle; trig held high while rst deasserts with mode = 1, burst_len = 2 -> burst starts immediately.

Source files
------------

// File: rtl/pulse_burst_generator.sv
// pulse_burst_generator
//
// A single period counter drives N_CHANNELS gate outputs. Each channel has
// its own delay and width inside the period. The block runs continuously
// (mode = 0) or runs bursts of burst_len periods started by a trig rising
// edge (mode = 1).
//
// Ports:
//   clk, rst      system clock; synchronous active-high reset
//   mode          0 = continuous, 1 = triggered burst
//   trig          level input. Its rising edge restarts the period in
//                 continuous mode and starts a burst in burst mode.
//   abort         forces IDLE on the next edge, with no done pulse
//   pulse_period  period length in clk cycles (0 and 1 both give 1-cycle periods)
//   pulse_delay   packed per-channel delay, channel i at [i*PPW +: PPW]
//   pulse_width   packed per-channel gate width, channel i at [i*PWW +: PWW]
//   burst_len     number of periods in a burst
//   valid         per-channel gate (registered)
//   cnt           counter value (registered)
//   start         high on the first cycle of each active period
//   busy          high while running (continuous or burst)
//   done          one-cycle pulse at burst completion, aligned with busy falling
//   pulse_idx     period index within the burst (0 when not bursting)
//
// Every output is a register loaded from the internal state. Each output
// therefore lags the state/counter by one cycle.
module pulse_burst_generator #(
    parameter int N_CHANNELS         = 2,
    parameter int PULSE_WIDTH_WIDTH  = 8,
    parameter int PULSE_PERIOD_WIDTH = 16,
    parameter int BURST_WIDTH        = 16
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     mode,
    input  logic                                     trig,
    input  logic                                     abort,
    input  logic [PULSE_PERIOD_WIDTH-1:0]            pulse_period,
    input  logic [N_CHANNELS*PULSE_PERIOD_WIDTH-1:0] pulse_delay,
    input  logic [N_CHANNELS*PULSE_WIDTH_WIDTH-1:0]  pulse_width,
    input  logic [BURST_WIDTH-1:0]                   burst_len,
    output logic [N_CHANNELS-1:0]                    valid,
    output logic [PULSE_PERIOD_WIDTH-1:0]            cnt,
    output logic                                     start,
    output logic                                     busy,
    output logic                                     done,
    output logic [BURST_WIDTH-1:0]                   pulse_idx
);

    localparam int PPW = PULSE_PERIOD_WIDTH;
    localparam int PWW = PULSE_WIDTH_WIDTH;
    localparam int BW  = BURST_WIDTH;

    localparam logic [PPW:0] ONE_P = 1;
    localparam logic [BW:0]  ONE_B = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONT  = 2'd1,
        BURST = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [PPW-1:0]  cnt_reg, cnt_nxt, cnt_inc;
    logic [BW-1:0]   idx, idx_nxt;
    logic            trig_d;
    logic            trig_rise;
    logic            active;
    logic            last;
    logic            burst_final;
    logic            done_evt;
    logic            done_evt_q;
    logic [PPW:0]    cnt_ext, cnt_sum;
    logic [BW:0]     idx_sum;
    logic [N_CHANNELS-1:0] valid_nxt;

    assign trig_rise = trig & ~trig_d;
    assign active    = (state != IDLE);

    // Compare in one extra bit so that cnt_reg + 1 cannot overflow. With a
    // period of 0 or 1 every cycle is a wrap. A period reduced below the
    // running count wraps at once.
    assign cnt_ext = {1'b0, cnt_reg};
    assign cnt_sum = cnt_ext + ONE_P;
    assign last    = (cnt_sum >= {1'b0, pulse_period});
    assign cnt_inc = last ? '0 : cnt_sum[PPW-1:0];

    // The final-period test uses >= and not ==. A burst_len lowered below
    // the current index then still ends the burst at the next wrap. It does
    // not run on until the index rolls over.
    assign idx_sum     = {1'b0, idx} + ONE_B;
    assign burst_final = (idx_sum >= {1'b0, burst_len});

    // Per-channel gate window [delay, delay + width) on the current count.
    // The count never reaches pulse_period. Windows are therefore cut off
    // at the wrap, and delays at or past the period never open.
    for (genvar g = 0; g < N_CHANNELS; g++) begin : g_ch
        logic [PPW-1:0] ch_delay;
        logic [PWW-1:0] ch_width;
        logic [PPW:0]   ch_off;
        assign ch_delay     = pulse_delay[g*PPW +: PPW];
        assign ch_width     = pulse_width[g*PWW +: PWW];
        assign ch_off       = cnt_ext - {1'b0, ch_delay};
        assign valid_nxt[g] = active & (cnt_reg >= ch_delay) &
                              (ch_off < (PPW+1)'(ch_width));
    end

    // Next-state logic. Abort takes priority over trig and wrap. Reset takes
    // priority over all of these in the register block below.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_reg;
        idx_nxt   = idx;
        done_evt  = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            idx_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_nxt = '0;
                    idx_nxt = '0;
                    if (!mode) begin
                        state_nxt = CONT;
                    end else if (trig_rise && (burst_len != '0)) begin
                        state_nxt = BURST;
                    end
                end
                CONT: begin
                    idx_nxt = '0;
                    // Switching to burst mode takes effect only at the end of
                    // the current period.
                    if (last && mode) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (trig_rise) begin
                        cnt_nxt = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                BURST: begin
                    // trig and mode are ignored for the whole burst.
                    cnt_nxt = cnt_inc;
                    if (last) begin
                        if (burst_final) begin
                            state_nxt = IDLE;
                            idx_nxt   = '0;
                            done_evt  = 1'b1;
                        end else begin
                            idx_nxt = idx_sum[BW-1:0];
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt_reg    <= '0;
            idx        <= '0;
            trig_d     <= 1'b0;
            done_evt_q <= 1'b0;
            cnt        <= '0;
            busy       <= 1'b0;
            start      <= 1'b0;
            pulse_idx  <= '0;
            valid      <= '0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt_reg    <= cnt_nxt;
            idx        <= idx_nxt;
            trig_d     <= trig;
            done_evt_q <= done_evt;
            cnt        <= cnt_reg;
            busy       <= active;
            start      <= active & (cnt_reg == '0);
            pulse_idx  <= idx;
            valid      <= valid_nxt;
            // done_evt is raised on the final wrap edge. busy drops one edge
            // later. The extra stage lines done up with the falling busy.
            done       <= done_evt_q;
        end
    end

endmodule

// File: tb/tb_pulse_burst_generator.sv
module tb_pulse_burst_generator;

    localparam int N   = 2;
    localparam int PWW = 8;
    localparam int PPW = 16;
    localparam int BW  = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 mode;
    logic                 trig;
    logic                 abort;
    logic [PPW-1:0]       pulse_period;
    logic [N*PPW-1:0]     pulse_delay;
    logic [N*PWW-1:0]     pulse_width;
    logic [BW-1:0]        burst_len;
    logic [N-1:0]         valid;
    logic [PPW-1:0]       cnt;
    logic                 start;
    logic                 busy;
    logic                 done;
    logic [BW-1:0]        pulse_idx;

    pulse_burst_generator #(
        .N_CHANNELS(N), .PULSE_WIDTH_WIDTH(PWW),
        .PULSE_PERIOD_WIDTH(PPW), .BURST_WIDTH(BW)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .trig(trig), .abort(abort),
        .pulse_period(pulse_period), .pulse_delay(pulse_delay),
        .pulse_width(pulse_width), .burst_len(burst_len),
        .valid(valid), .cnt(cnt), .start(start), .busy(busy),
        .done(done), .pulse_idx(pulse_idx)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks "what the generator is doing" as run kind, position within the
    // period and period number. It publishes the outputs one edge late.
    int m_kind;   // 0 stopped, 1 free running, 2 bursting
    int m_phase;
    int m_pno;
    bit m_tprev;
    bit m_fin;
    logic [N-1:0] e_valid = '0;
    int e_cnt = 0, e_idx = 0;
    bit e_start = 0, e_busy = 0, e_done = 0;

    always @(posedge clk) begin : model
        int per, blen, d, w;
        bit rise, eop;
        if (rst) begin
            m_kind = 0; m_phase = 0; m_pno = 0; m_tprev = 0; m_fin = 0;
            e_valid = '0; e_cnt = 0; e_idx = 0; e_start = 0; e_busy = 0; e_done = 0;
        end else begin
            per  = int'(pulse_period);
            blen = int'(burst_len);
            e_busy  = (m_kind != 0);
            e_cnt   = m_phase;
            e_idx   = m_pno;
            e_start = e_busy && (m_phase == 0);
            for (int i = 0; i < N; i++) begin
                d = int'(pulse_delay[i*PPW +: PPW]);
                w = int'(pulse_width[i*PWW +: PWW]);
                e_valid[i] = e_busy && (m_phase >= d) && (m_phase < d + w);
            end
            e_done = m_fin;
            m_fin  = 0;
            rise    = trig && !m_tprev;
            m_tprev = trig;
            eop = (m_phase + 1 >= per);
            if (abort) begin
                m_kind = 0; m_phase = 0; m_pno = 0;
            end else if (m_kind == 0) begin
                m_phase = 0; m_pno = 0;
                if (!mode) m_kind = 1;
                else if (rise && blen != 0) m_kind = 2;
            end else if (m_kind == 1) begin
                if (eop && mode) begin
                    m_kind = 0; m_phase = 0;
                end else if (rise) m_phase = 0;
                else m_phase = eop ? 0 : m_phase + 1;
            end else begin
                m_phase = eop ? 0 : m_phase + 1;
                if (eop) begin
                    if (m_pno + 1 >= blen) begin
                        m_kind = 0; m_pno = 0; m_fin = 1;
                    end else m_pno = m_pno + 1;
                end
            end
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("sb_busy",  busy,      e_busy);
            chk("sb_cnt",   cnt,       e_cnt);
            chk("sb_start", start,     e_start);
            chk("sb_valid", valid,     e_valid);
            chk("sb_done",  done,      e_done);
            chk("sb_idx",   pulse_idx, e_idx);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_ch(input int i, input int d, input int w);
        pulse_delay[i*PPW +: PPW] = PPW'(d);
        pulse_width[i*PWW +: PWW] = PWW'(w);
    endtask

    task automatic wait_idle(input string name);
        bit found = 0;
        for (int k = 0; k < 100; k++) begin
            if (!busy) begin found = 1; break; end
            tick();
        end
        chk(name, found, 1);
    endtask

    task automatic wait_at(input string name, input int c, input int ix, input bit use_idx);
        bit found = 0;
        for (int k = 0; k < 100; k++) begin
            if (busy && cnt == PPW'(c) && (!use_idx || pulse_idx == BW'(ix))) begin
                found = 1; break;
            end
            tick();
        end
        chk(name, found, 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin : stim
        int nb, ns, nd, n, lastc, nv;
        bit pb;
        rst = 1; mode = 0; trig = 0; abort = 0;
        pulse_period = 16'd5; pulse_delay = '0; pulse_width = '0; burst_len = '0;
        set_ch(0, 1, 2);
        set_ch(1, 0, 5);
        tick();
        chk_en = 1;
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_valid", valid, 0);
        chk("rst_start", start, 0);
        chk("rst_done", done, 0);
        chk("rst_idx", pulse_idx, 0);

        // continuous, period 5
        rst = 0;
        tick();
        chk("t1_busy_lag", busy, 0);
        tick();
        for (int k = 0; k < 10; k++) begin
            chk("t1_busy", busy, 1);
            chk("t1_cnt", cnt, k % 5);
            chk("t1_valid0", valid[0], (k % 5 >= 1) && (k % 5 <= 2));
            chk("t1_valid1", valid[1], 1);
            chk("t1_start", start, (k % 5) == 0);
            tick();
        end

        // burst of 3 periods of 4, second trig mid-burst ignored
        mode = 1;
        wait_idle("t2_idle_timeout");
        pulse_period = 16'd4; burst_len = 16'd3;
        nb = 0; ns = 0; nd = 0; pb = 0;
        for (int t = 0; t < 30; t++) begin
            trig = (t == 0 || t == 5);
            tick();
            if (busy) nb++;
            if (start) begin
                chk("t2_idx_at_start", pulse_idx, ns);
                ns++;
            end
            if (done) begin
                nd++;
                chk("t2_done_with_busy_fall", {busy, pb}, 2'b01);
            end
            pb = busy;
        end
        trig = 0;
        chk("t2_busy_cycles", nb, 12);
        chk("t2_starts", ns, 3);
        chk("t2_dones", nd, 1);

        // abort during idx 1
        trig = 1; tick(); trig = 0;
        wait_at("t3_wait_timeout", 2, 1, 1);
        abort = 1; tick(); abort = 0;
        chk("t3_busy_hold", busy, 1);
        tick();
        chk("t3_busy_off", busy, 0);
        chk("t3_valid_off", valid, 0);
        nb = 0; nd = 0;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (busy) nb++;
            if (done) nd++;
        end
        chk("t3_no_busy", nb, 0);
        chk("t3_no_done", nd, 0);

        // period 0 and 1
        mode = 0; pulse_period = 16'd0;
        tick(); tick(); tick();
        for (int k = 0; k < 4; k++) begin
            chk("t4_p0_cnt", cnt, 0);
            chk("t4_p0_start", start, 1);
            tick();
        end
        pulse_period = 16'd1;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("t4_p1_cnt", cnt, 0);
            chk("t4_p1_start", start, 1);
            tick();
        end
        // delay beyond period
        pulse_period = 16'd6; set_ch(0, 7, 3);
        for (int k = 0; k < 12; k++) begin
            chk("t4_delay_out", valid[0], 0);
            tick();
        end
        // zero width
        set_ch(0, 1, 0);
        for (int k = 0; k < 12; k++) begin
            chk("t4_width0", valid[0], 0);
            tick();
        end
        // window 4..8 truncated at period end (cnt 5): two cycles per period
        set_ch(0, 4, 5);
        tick();
        nv = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (valid[0]) nv++;
        end
        chk("t4_trunc_count", nv, 4);
        // burst_len 0 ignored
        mode = 1;
        wait_idle("t4_idle_timeout");
        burst_len = 16'd0;
        trig = 1; tick(); trig = 0;
        nb = 0; nd = 0;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (busy) nb++;
            if (done) nd++;
        end
        chk("t4_blen0_busy", nb, 0);
        chk("t4_blen0_done", nd, 0);

        // continuous restart and mode switch
        mode = 0; pulse_period = 16'd10; burst_len = 16'd3;
        wait_at("t5_wait3_timeout", 3, 0, 0);
        trig = 1; tick(); tick();
        chk("t5_restart_cnt", cnt, 0);
        trig = 0;
        wait_at("t5_wait5_timeout", 5, 0, 0);
        mode = 1;
        n = 0; lastc = -1;
        for (int k = 0; k < 30; k++) begin
            tick();
            n++;
            if (!busy) break;
            lastc = int'(cnt);
        end
        chk("t5_switch_ticks", n, 5);
        chk("t5_last_cnt", lastc, 9);

        // reset mid-burst, then trig held through reset release
        pulse_period = 16'd4; burst_len = 16'd3;
        trig = 1; tick(); trig = 0;
        for (int k = 0; k < 5; k++) tick();
        rst = 1; tick();
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_cnt", cnt, 0);
        chk("t6_rst_valid", valid, 0);
        chk("t6_rst_start", start, 0);
        chk("t6_rst_idx", pulse_idx, 0);
        trig = 1; burst_len = 16'd2;
        tick();
        rst = 0;
        tick();
        chk("t6_busy_lag", busy, 0);
        nb = 0; nd = 0; ns = 0;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (busy) nb++;
            if (done) nd++;
            if (start) ns++;
        end
        trig = 0;
        chk("t6_busy_cycles", nb, 8);
        chk("t6_dones", nd, 1);
        chk("t6_starts", ns, 2);

        tick();
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
